// File: rtl/ctrlsoc_uart.sv
// ctrlsoc_uart: memory-mapped UART on the PicoRV32 native (valid/ready) bus.
//
// Register window (word index = mem_addr):
//   0 DATA   read pops RX FIFO ([31] = empty, [7:0] = byte); write pushes TX FIFO
//   1 DIV    [15:0] clk cycles per bit, values below 4 stored as 4
//   2 STATUS [0] RX non-empty, [1] TX full, [2] TX idle, [3] RX overrun,
//            [4] framing error, [5] parity error, [8] parity enable, [9] odd parity
//   3        reads 0, writes ignored
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   rx / tx             serial input (asynchronous) / serial output
//   mem_valid/mem_ready request / single-cycle completion pulse
//   mem_addr            word index, mem_wstrb write strobes (0 = read)
//   mem_wdata/mem_rdata write / read data
//
// Optional feature: define CTRLSOC_UART_PARITY_EN to implement the parity bit,
// STATUS bits 5, 8 and 9. Without it every frame is 8N1.

module ctrlsoc_uart #(
    parameter int CLKDIV_RESET = 104,
    parameter int RX_DEPTH     = 4,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic        mem_valid,
    input  logic [1:0]  mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [15:0]    DIV_RESET   = 16'(CLKDIV_RESET);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [15:0] div;
    logic        par_en, par_odd;
    logic        err_overrun, err_frame, err_parity;

    logic        access, is_write, rd_data, wr_data, wr_div, clr_flags, stall;
    logic [31:0] rd_value, status_word;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_empty, rx_full, rx_pop, rx_push, rx_push_req, rx_overrun_evt;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_empty, tx_full, tx_pop, tx_push, tx_idle;

    tx_state_t   tx_state;
    logic [15:0] tx_div, tx_cnt;
    logic [10:0] tx_frame, tx_new_frame;
    logic [3:0]  tx_bits_left, tx_new_bits;
    logic [7:0]  tx_head;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync, rx_last;
    logic [15:0] rx_div, rx_cnt;
    logic [2:0]  rx_bit_idx;
    logic [7:0]  rx_shift;
    logic        rx_stop_event, rx_frame_err, rx_par_err;

    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[31:16];

    // Bus decode. A request is taken only while mem_ready is low, so each
    // access has exactly one side effect. A DATA write into a full TX FIFO
    // is only taken on the edge where the TX engine frees an entry.
    assign access    = mem_valid && !mem_ready;
    assign is_write  = |mem_wstrb;
    assign rd_data   = access && !is_write && (mem_addr == 2'd0);
    assign wr_data   = access && is_write && (mem_addr == 2'd0) && mem_wstrb[0];
    assign wr_div    = access && is_write && (mem_addr == 2'd1);
    assign clr_flags = access && is_write && (mem_addr == 2'd2) && mem_wstrb[0];
    assign stall     = wr_data && tx_full && !tx_pop;
    assign tx_push   = wr_data && (!tx_full || tx_pop);
    assign rx_pop    = rd_data && !rx_empty;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
    assign tx_head  = tx_mem[tx_rd_ptr];

    assign status_word = {22'h0, par_odd, par_en, 2'b00, err_parity, err_frame,
                          err_overrun, tx_idle, tx_full, !rx_empty};

    // Read mux; writes complete with zero read data.
    always_comb begin
        rd_value = '0;
        if (!is_write) begin
            case (mem_addr)
                2'd0:    rd_value = rx_empty ? 32'h8000_0000 : {24'h0, rx_mem[rx_rd_ptr]};
                2'd1:    rd_value = {16'h0, div};
                2'd2:    rd_value = status_word;
                default: rd_value = '0;
            endcase
        end
    end

    // Registered bus response: ready and data appear the cycle after the take.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else if (access && !stall) begin
            mem_ready <= 1'b1;
            mem_rdata <= rd_value;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end
    end

    // Divider and sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= DIV_RESET;
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            if (wr_div)
                div <= (mem_wdata[15:0] < 16'd4) ? 16'd4 : mem_wdata[15:0];
            err_overrun <= (err_overrun & ~(clr_flags & mem_wdata[3])) | rx_overrun_evt;
            err_frame   <= (err_frame & ~(clr_flags & mem_wdata[4])) | rx_frame_err;
        end
    end

`ifdef CTRLSOC_UART_PARITY_EN
    // Parity configuration and parity-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            if (access && is_write && (mem_addr == 2'd2) && mem_wstrb[1])
                {par_odd, par_en} <= mem_wdata[9:8];
            err_parity <= (err_parity & ~(clr_flags & mem_wdata[5])) | rx_par_err;
        end
    end

    assign tx_new_frame = par_en ? {1'b1, ^tx_head ^ par_odd, tx_head, 1'b0}
                                 : {2'b11, tx_head, 1'b0};
    assign tx_new_bits  = par_en ? 4'd11 : 4'd10;
`else
    assign par_en       = 1'b0;
    assign par_odd      = 1'b0;
    assign err_parity   = 1'b0;
    assign tx_new_frame = {2'b11, tx_head, 1'b0};
    assign tx_new_bits  = 4'd10;
`endif

    // TX FIFO; a push may coincide with a pop even when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= mem_wdata[7:0];
                tx_wr_ptr         <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // The engine pops when idle or as its stop bit ends, then spends one
    // LOAD cycle before driving the start bit.
    assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) ||
                    ((tx_state == TX_SEND) && (tx_cnt == '0) && (tx_bits_left == 4'd1)));

    // TX engine: the frame is shifted out LSB first, refilled with stop-level ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state     <= TX_IDLE;
            tx           <= 1'b1;
            tx_div       <= DIV_RESET;
            tx_cnt       <= '0;
            tx_frame     <= '1;
            tx_bits_left <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_div       <= div;
                        tx_frame     <= tx_new_frame;
                        tx_bits_left <= tx_new_bits;
                        tx_state     <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx       <= tx_frame[0];
                    tx_frame <= {1'b1, tx_frame[10:1]};
                    tx_cnt   <= tx_div - 16'd1;
                    tx_state <= TX_SEND;
                end
                TX_SEND: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else if (tx_bits_left == 4'd1) begin
                        if (tx_pop) begin
                            tx_div       <= div;
                            tx_frame     <= tx_new_frame;
                            tx_bits_left <= tx_new_bits;
                            tx_state     <= TX_LOAD;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx           <= tx_frame[0];
                        tx_frame     <= {1'b1, tx_frame[10:1]};
                        tx_cnt       <= tx_div - 16'd1;
                        tx_bits_left <= tx_bits_left - 4'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Frame outcome is decided at the stop-bit sample point.
    assign rx_stop_event  = (rx_state == RX_STOP) && (rx_cnt == '0);
    assign rx_frame_err   = rx_stop_event && !rx_sync;
    assign rx_push_req    = rx_stop_event && rx_sync && !rx_par_err;
    assign rx_push        = rx_push_req && (!rx_full || rx_pop);
    assign rx_overrun_evt = rx_push_req && rx_full && !rx_pop;

`ifdef CTRLSOC_UART_PARITY_EN
    logic rx_par_en_l, rx_par_odd_l, rx_par_bit;
    assign rx_par_err = rx_stop_event && rx_sync && rx_par_en_l &&
                        (rx_par_bit != (^rx_shift ^ rx_par_odd_l));

    // RX parity settings are captured at the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_par_en_l  <= 1'b0;
            rx_par_odd_l <= 1'b0;
            rx_par_bit   <= 1'b0;
        end else begin
            if ((rx_state == RX_IDLE) && rx_last && !rx_sync) begin
                rx_par_en_l  <= par_en;
                rx_par_odd_l <= par_odd;
            end
            if ((rx_state == RX_PARITY) && (rx_cnt == '0))
                rx_par_bit <= rx_sync;
        end
    end
`else
    assign rx_par_err = 1'b0;
`endif

    // RX FIFO; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= rx_shift;
                rx_wr_ptr         <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // RX engine: synchronise, detect start edge, sample mid-bit. The
    // synchroniser resets high so reset release cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_last    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_div     <= DIV_RESET;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_last && !rx_sync) begin
                        rx_div   <= div;
                        rx_cnt   <= {1'b0, div[15:1]} - 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt     <= rx_div - 16'd1;
                        rx_bit_idx <= '0;
                        rx_state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift   <= {rx_sync, rx_shift[7:1]};
                        rx_cnt     <= rx_div - 16'd1;
                        rx_bit_idx <= rx_bit_idx + 3'd1;
                        if (rx_bit_idx == 3'd7) begin
`ifdef CTRLSOC_UART_PARITY_EN
                            rx_state <= rx_par_en_l ? RX_PARITY : RX_STOP;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_cnt   <= rx_div - 16'd1;
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0)
                        rx_cnt <= rx_cnt - 16'd1;
                    else
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlsoc_uart.sv
// tb_ctrlsoc_uart: directed self-checking bench for ctrlsoc_uart.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_ctrlsoc_uart;

    localparam int RXD   = 4;
    localparam int TXD   = 4;
    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        mem_valid;
    logic [1:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] txBytes [TXD+2];

    ctrlsoc_uart #(
        .CLKDIV_RESET(104),
        .RX_DEPTH(RXD),
        .TX_DEPTH(TXD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .tx(tx),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Hard stop in case anything escapes its own bound.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus access; returns read data and the number of cycles until ready.
    task automatic applyStimulus(input logic [1:0] addr, input logic [3:0] strb,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int waitCycles);
        @(negedge clk);
        mem_valid  = 1'b1;
        mem_addr   = addr;
        mem_wstrb  = strb;
        mem_wdata  = wdata;
        waitCycles = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (mem_ready !== 1'b1 && waitCycles < LIMIT);
        checkOutput("bus_ready", {31'h0, mem_ready}, 32'd1);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr,
                             input logic [31:0] expected);
        logic [31:0] d;
        int w;
        applyStimulus(addr, 4'h0, '0, d, w);
        checkOutput(tag, d, expected);
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [3:0] strb,
                            input logic [31:0] data);
        logic [31:0] d;
        int w;
        applyStimulus(addr, strb, data, d, w);
    endtask

    task automatic driveBit(input logic b, input int div);
        rx = b;
        repeat (div) @(negedge clk);
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input logic stopBit, input int div,
                               input logic withParity, input logic parityBit);
        @(negedge clk);
        driveBit(1'b0, div);
        for (int i = 0; i < 8; i++) driveBit(data[i], div);
        if (withParity) driveBit(parityBit, div);
        driveBit(stopBit, div);
        driveBit(1'b1, 2 * div);
    endtask

    // Waits for a start bit then samples each bit mid-period; bits[0] is the start bit.
    task automatic captureTxFrame(input int div, input int nbits,
                                  output logic [10:0] bits, output int latency);
        bits    = '1;
        latency = 0;
        while (tx !== 1'b0 && latency < LIMIT) begin
            @(negedge clk);
            latency++;
        end
        checkOutput("tx_start_seen", {31'h0, tx}, 32'd0);
        repeat (div / 2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bits[i] = tx;
            if (i != nbits - 1) repeat (div) @(negedge clk);
        end
    endtask

    initial begin
        logic [10:0] bits;
        int          lat;

        txBytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        reset     = 1'b1;
        rx        = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 2'd0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", {31'h0, tx}, 32'd1);
        checkOutput("reset_ready", {31'h0, mem_ready}, 32'd0);
        checkOutput("reset_rdata", mem_rdata, 32'd0);
        reset = 1'b0;

        // Reset register values and the unused word.
        readCheck("div_reset", 2'd1, 32'd104);
        readCheck("status_reset", 2'd2, 32'h4);
        readCheck("data_empty", 2'd0, 32'h8000_0000);
        writeReg(2'd3, 4'hF, 32'hFFFF_FFFF);
        readCheck("word3", 2'd3, 32'h0);
        checkOutput("tx_idle_high", {31'h0, tx}, 32'd1);

        // Divider floor: 2 is stored as 4.
        writeReg(2'd1, 4'h3, 32'd2);
        readCheck("div_floor", 2'd1, 32'd4);

        // TX 0x55 at DIV=4: start 0, data 1010..., stop 1.
        writeReg(2'd0, 4'h1, 32'h55);
        captureTxFrame(4, 10, bits, lat);
        checkOutput("tx_latency", 32'(lat), 32'd2);
        checkOutput("tx_frame_55", {21'h0, bits}, 32'h6AA);
        repeat (6) @(negedge clk);
        readCheck("status_tx_done", 2'd2, 32'h4);

        // Five RX frames into a 4-deep FIFO: the fifth overruns.
        writeReg(2'd1, 4'h3, 32'd8);
        for (int i = 0; i < 5; i++) sendRxFrame(8'h11 + 8'(i), 1'b1, 8, 1'b0, 1'b0);
        readCheck("status_overrun", 2'd2, 32'hD);
        for (int i = 0; i < 4; i++) readCheck("rx_data", 2'd0, 32'h11 + 32'(i));
        readCheck("rx_empty_after", 2'd0, 32'h8000_0000);
        readCheck("overrun_sticky", 2'd2, 32'hC);
        writeReg(2'd2, 4'h1, 32'h8);
        readCheck("overrun_cleared", 2'd2, 32'h4);

        // Framing error: stop bit 0.
        sendRxFrame(8'hA5, 1'b0, 8, 1'b0, 1'b0);
        readCheck("status_frame_err", 2'd2, 32'h14);
        readCheck("frame_dropped", 2'd0, 32'h8000_0000);
        writeReg(2'd2, 4'h1, 32'h10);
        readCheck("frame_err_cleared", 2'd2, 32'h4);

        // Short glitch is rejected, then a clean frame still arrives.
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        readCheck("glitch_status", 2'd2, 32'h4);
        readCheck("glitch_no_data", 2'd0, 32'h8000_0000);
        sendRxFrame(8'h3C, 1'b1, 8, 1'b0, 1'b0);
        readCheck("rx_after_glitch", 2'd0, 32'h3C);

        // TX_DEPTH+2 back-to-back writes: the final write must wait for a pop.
        writeReg(2'd1, 4'h3, 32'd4);
        fork
            begin
                logic [31:0] d;
                int          w;
                for (int i = 0; i < TXD + 2; i++) begin
                    applyStimulus(2'd0, 4'h1, {24'h0, txBytes[i]}, d, w);
                    if (i < TXD) checkOutput("tx_write_no_stall", 32'(w), 32'd1);
                    if (i == TXD + 1) checkOutput("tx_write_stalled", {31'h0, w > 1}, 32'd1);
                end
                readCheck("status_tx_full", 2'd2, 32'h2);
            end
            begin
                logic [10:0] fb;
                int          fl;
                for (int i = 0; i < TXD + 2; i++) begin
                    captureTxFrame(4, 10, fb, fl);
                    checkOutput("tx_order", {21'h0, fb}, {21'h0, 2'b11, txBytes[i], 1'b0});
                end
            end
        join
        repeat (6) @(negedge clk);
        readCheck("status_after_burst", 2'd2, 32'h4);

`ifdef CTRLSOC_UART_PARITY_EN
        // Odd parity: 0x03 has two ones, so the parity bit is 1.
        writeReg(2'd2, 4'h2, 32'h300);
        readCheck("parity_cfg", 2'd2, 32'h304);
        writeReg(2'd0, 4'h1, 32'h03);
        captureTxFrame(4, 11, bits, lat);
        checkOutput("tx_parity_frame", {21'h0, bits}, 32'h606);
        repeat (6) @(negedge clk);
        sendRxFrame(8'h03, 1'b1, 4, 1'b1, 1'b0);
        readCheck("status_parity_err", 2'd2, 32'h324);
        readCheck("parity_dropped", 2'd0, 32'h8000_0000);
        sendRxFrame(8'h03, 1'b1, 4, 1'b1, 1'b1);
        readCheck("parity_ok_data", 2'd0, 32'h03);
        writeReg(2'd2, 4'h1, 32'h20);
        readCheck("parity_err_cleared", 2'd2, 32'h304);
        writeReg(2'd2, 4'h2, 32'h0);
        readCheck("parity_disabled", 2'd2, 32'h4);
`else
        // Without parity support the configuration bits stay 0.
        writeReg(2'd2, 4'h2, 32'h300);
        readCheck("parity_ignored", 2'd2, 32'h4);
`endif

        // Reset in the middle of a frame returns tx high on the next cycle.
        writeReg(2'd1, 4'h3, 32'd8);
        writeReg(2'd0, 4'h1, 32'h00);
        lat = 0;
        while (tx !== 1'b0 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        repeat (12) @(negedge clk);
        checkOutput("tx_mid_frame_low", {31'h0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("tx_reset_abandon", {31'h0, tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        readCheck("div_after_reset", 2'd1, 32'd104);
        readCheck("status_after_reset", 2'd2, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
